// File: rtl/nand_sweep_pkg.sv
// rtl/nand_sweep_pkg.sv - shared state type and default sizing for the NAND sweep checker
package nand_sweep_pkg;

    localparam int N_INPUTS_DEF      = 5;
    localparam int SETTLE_CYCLES_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/nand_sweep_ref.sv
// rtl/nand_sweep_ref.sv - combinational N-input NAND reference model
module nand_sweep_ref
    import nand_sweep_pkg::*;
#(
    parameter int N_INPUTS = N_INPUTS_DEF
) (
    input  logic [N_INPUTS-1:0] vec_i,
    output logic                nand_o
);

    assign nand_o = ~(&vec_i);

endmodule

// File: rtl/nand_sweep_checker.sv
// rtl/nand_sweep_checker.sv - exhaustive NAND gate sweep with mismatch counting
// Optional NAND_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module nand_sweep_checker
    import nand_sweep_pkg::*;
#(
    parameter int N_INPUTS      = N_INPUTS_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [N_INPUTS-1:0] stim,
    input  logic                duv_o,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS:0]   err_count,
    output logic [N_INPUTS-1:0] first_fail
);

    localparam logic [7:0]          SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [N_INPUTS-1:0] STIM_ONE    = {{(N_INPUTS-1){1'b0}}, 1'b1};
    localparam logic [N_INPUTS:0]   ERR_ONE     = {{N_INPUTS{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [N_INPUTS-1:0] stim_q, stim_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [N_INPUTS:0]   err_q, err_d;
    logic [N_INPUTS-1:0] ff_q, ff_d;
    logic                busy_q, done_q, pass_q;
    logic                exp_nand;
    logic                mismatch;
    logic                stop;

    nand_sweep_ref #(
        .N_INPUTS (N_INPUTS)
    ) u_ref (
        .vec_i  (stim_q),
        .nand_o (exp_nand)
    );

    // Case inequality so an unknown DUV output is reported as a failure.
    assign mismatch = (duv_o !== exp_nand);

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ff_d    = ff_q;
        stop    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    stim_d  = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + ERR_ONE;
                    if (err_q == '0) begin
                        ff_d = stim_q;
                    end
`ifdef NAND_SWEEP_STOP_ON_FAIL_EN
                    stop = 1'b1;
`else
                    stop = 1'b0;
`endif
                end
                if (stop || (stim_q == '1)) begin
                    state_d = ST_DONE;
                end else begin
                    stim_d  = stim_q + STIM_ONE;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status flags are derived from next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stim_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            busy_q  <= (state_d == ST_SETTLE) || (state_d == ST_CHECK);
            done_q  <= (state_d == ST_DONE);
            pass_q  <= (state_d == ST_DONE) && (err_d == '0);
        end
    end

    assign stim       = stim_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule
